// File: rtl/fp_pkg.sv
// Shared definitions for the FP result composer: default widths, status/flag
// bit positions, the path selector enum and canonical special-value encodings.
package fp_pkg;

    localparam bit IS_DOUBLE = 1'b0;
    localparam int EXP_W     = IS_DOUBLE ? 11 : 8;
    localparam int MANT_W    = IS_DOUBLE ? 52 : 23;

    localparam int STAT_W       = 4;
    localparam int STAT_NAN     = 3;
    localparam int STAT_INF     = 2;
    localparam int STAT_ZERO    = 1;
    localparam int STAT_INVALID = 0;

    localparam int FLAG_W      = 3;
    localparam int FLG_INVALID = 2;
    localparam int FLG_OVF     = 1;
    localparam int FLG_UNF     = 0;

    typedef enum logic [2:0] {
        PATH_NORM = 3'd0,
        PATH_NAN  = 3'd1,
        PATH_INF  = 3'd2,
        PATH_ZERO = 3'd3,
        PATH_OVF  = 3'd4,
        PATH_UNF  = 3'd5
    } path_e;

    // Returned 64 bits wide so one function serves every format; callers truncate.
    function automatic logic [63:0] qnan_word(input int ew, input int mw);
        logic [63:0] w;
        w = ((64'd1 << ew) - 64'd1) << mw;
        w = w | (64'd1 << (mw - 1));
        return w;
    endfunction

    function automatic logic [63:0] inf_word(input logic sign, input int ew, input int mw);
        logic [63:0] w;
        w = ((64'd1 << ew) - 64'd1) << mw;
        w = w | (64'(sign) << (ew + mw));
        return w;
    endfunction

endpackage

// File: rtl/fp_result_composer_if.sv
// Bus bundle for fp_result_composer: input beat, output result and sticky flags.
// master = producer/consumer side, slave = composer side.
interface fp_result_composer_if
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_W,
    parameter int MANT_WIDTH = MANT_W
);

    logic                            in_valid;
    logic                            in_ready;
    logic [STAT_W-1:0]               in_status;
    logic                            in_sign;
    logic [EXP_WIDTH+1:0]            in_exp;
    logic [MANT_WIDTH:0]             in_mant;
    logic                            out_valid;
    logic                            out_ready;
    logic [EXP_WIDTH+MANT_WIDTH:0]   out_result;
    logic [FLAG_W-1:0]               out_flags;
    logic [FLAG_W-1:0]               sticky_flags;
    logic                            flags_clear;

    modport master (
        output in_valid, in_status, in_sign, in_exp, in_mant, out_ready, flags_clear,
        input  in_ready, out_valid, out_result, out_flags, sticky_flags
    );

    modport slave (
        input  in_valid, in_status, in_sign, in_exp, in_mant, out_ready, flags_clear,
        output in_ready, out_valid, out_result, out_flags, sticky_flags
    );

endinterface

// File: rtl/fp_pipe_stage.sv
// Single-entry valid/ready register slice; loads when empty or when downstream accepts.
module fp_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    assign in_ready_o = !rst && (!valid_q || out_ready_i);
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/fp_result_composer.sv
// Composes the final IEEE-754 word from operation status and raw sign/exp/mant.
// Define FP_DENORM_OUT_EN to produce denormals instead of flushing underflow to zero.
module fp_result_composer
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_W,
    parameter int MANT_WIDTH = MANT_W
) (
    input  logic                clk,
    input  logic                rst,
    fp_result_composer_if.slave bus
);

    localparam int RES_W = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int PAY_W = RES_W + FLAG_W;
    localparam int XW    = EXP_WIDTH + 2;

    localparam logic [RES_W-1:0]     QNAN_C   = RES_W'(qnan_word(EXP_WIDTH, MANT_WIDTH));
    localparam logic [RES_W-1:0]     INF_C    = RES_W'(inf_word(1'b0, EXP_WIDTH, MANT_WIDTH));
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;
    localparam logic signed [XW-1:0] EXP_OVF  = $signed({2'b00, EXP_ONES});

    logic signed [XW-1:0]  exp_s;
    path_e                 path;
    logic [MANT_WIDTH-1:0] unf_mant;
    logic                  unf_flag;
    logic [RES_W-1:0]      s1_result;
    logic [FLAG_W-1:0]     s1_flags;
    logic [RES_W-1:0]      sign_bit;

    assign exp_s    = $signed(bus.in_exp);
    assign sign_bit = {bus.in_sign, {(RES_W-1){1'b0}}};

    always_comb begin
        path = PATH_NORM;
        if (bus.in_status[STAT_NAN]) begin
            path = PATH_NAN;
        end else if (bus.in_status[STAT_INF]) begin
            path = PATH_INF;
        end else if (bus.in_status[STAT_ZERO]) begin
            path = PATH_ZERO;
        end else if (exp_s >= EXP_OVF) begin
            path = PATH_OVF;
        end else if (exp_s[XW-1] || (exp_s == '0)) begin
            path = PATH_UNF;
        end
    end

`ifdef FP_DENORM_OUT_EN
    localparam int SH_W = $clog2(MANT_WIDTH + 2);
    localparam logic signed [XW-1:0] EXP_DMIN = XW'(1 - MANT_WIDTH);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

    logic signed [XW-1:0] shamt_x;
    logic [SH_W-1:0]      shamt;
    logic [MANT_WIDTH:0]  den_shifted;
    logic [MANT_WIDTH:0]  den_lost_mask;
    logic                 unused_shift;

    // shamt is only meaningful inside the denormal window, where it is 1..MANT_WIDTH.
    always_comb begin
        shamt_x       = EXP_ONE - exp_s;
        shamt         = shamt_x[SH_W-1:0];
        den_shifted   = bus.in_mant >> shamt;
        den_lost_mask = ~({(MANT_WIDTH+1){1'b1}} << shamt);
        if (exp_s >= EXP_DMIN) begin
            unf_mant = den_shifted[MANT_WIDTH-1:0];
            unf_flag = (|(bus.in_mant & den_lost_mask)) || (unf_mant == '0);
        end else begin
            unf_mant = '0;
            unf_flag = 1'b1;
        end
    end

    assign unused_shift = ^{shamt_x[XW-1:SH_W], den_shifted[MANT_WIDTH]};
`else
    logic unused_hidden;

    assign unf_mant      = '0;
    assign unf_flag      = 1'b1;
    assign unused_hidden = bus.in_mant[MANT_WIDTH];
`endif

    always_comb begin
        s1_result = '0;
        s1_flags  = '0;
        unique case (path)
            PATH_NAN: begin
                s1_result             = QNAN_C;
                s1_flags[FLG_INVALID] = bus.in_status[STAT_INVALID];
            end
            PATH_INF:  s1_result = INF_C | sign_bit;
            PATH_ZERO: s1_result = sign_bit;
            PATH_OVF: begin
                s1_result         = INF_C | sign_bit;
                s1_flags[FLG_OVF] = 1'b1;
            end
            PATH_UNF: begin
                s1_result         = {bus.in_sign, {EXP_WIDTH{1'b0}}, unf_mant};
                s1_flags[FLG_UNF] = unf_flag;
            end
            default: s1_result = {bus.in_sign, bus.in_exp[EXP_WIDTH-1:0],
                                  bus.in_mant[MANT_WIDTH-1:0]};
        endcase
    end

    logic             s1_in_ready, s1_valid;
    logic             s2_in_ready, s2_valid;
    logic [PAY_W-1:0] s1_pay_d, s1_pay_q, s2_pay_q;

    assign s1_pay_d = {s1_flags, s1_result};

    fp_pipe_stage #(.WIDTH(PAY_W)) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (s1_pay_d),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_pay_q)
    );

    fp_pipe_stage #(.WIDTH(PAY_W)) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s1_pay_q),
        .out_valid_o (s2_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (s2_pay_q)
    );

    assign bus.in_ready   = s1_in_ready;
    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_pay_q[RES_W-1:0];
    assign bus.out_flags  = s2_pay_q[PAY_W-1:RES_W];

    // A clear coinciding with a handshake keeps only the flags of that beat.
    logic              out_fire;
    logic [FLAG_W-1:0] sticky_q, sticky_d;

    assign out_fire = s2_valid && bus.out_ready;

    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_sticky
        assign sticky_d[gi] = out_fire ? ((sticky_q[gi] && !bus.flags_clear) || bus.out_flags[gi])
                                       : (sticky_q[gi] && !bus.flags_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_result_composer.sv
// Testbench for fp_result_composer (single precision): directed table, pipeline
// corner sequences and randomized beats against a behavioural model.
`timescale 1ns/1ps
module tb_fp_result_composer;
    import fp_pkg::*;

    localparam int EW    = 8;
    localparam int MW    = 23;
    localparam int NRAND = 150;
    localparam int NVEC  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_result_composer_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) bus ();

    fp_result_composer #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  st;
        logic        sg;
        logic [9:0]  ex;
        logic [23:0] mn;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the result-encoding rules, using integer arithmetic.
    function automatic void model(input logic [3:0] st, input logic sg, input logic [9:0] ex,
                                  input logic [23:0] mn, output logic [31:0] r, output logic [2:0] f);
        int     e;
        longint pw, m, lost, sgn;
        sgn = sg ? 64'h8000_0000 : 64'd0;
        f = 3'b000;
        e = int'($signed(ex));
        if (st[3]) begin
            r = 32'h7FC0_0000;
            f = st[0] ? 3'b100 : 3'b000;
        end else if (st[2]) begin
            r = 32'(sgn + 64'h7F80_0000);
        end else if (st[1]) begin
            r = 32'(sgn);
        end else if (e >= 255) begin
            r = 32'(sgn + 64'h7F80_0000);
            f = 3'b010;
        end else if (e <= 0) begin
`ifdef FP_DENORM_OUT_EN
            if (e >= -22) begin
                pw   = longint'(1) << (1 - e);
                m    = longint'(mn) / pw;
                lost = longint'(mn) % pw;
                r    = 32'(sgn + (m % (longint'(1) << 23)));
                f    = (lost != 0 || m == 0) ? 3'b001 : 3'b000;
            end else begin
                r = 32'(sgn);
                f = 3'b001;
            end
`else
            r = 32'(sgn);
            f = 3'b001;
`endif
        end else begin
            r = 32'(sgn + longint'(e) * 64'h80_0000 + (longint'(mn) % 64'h80_0000));
        end
    endfunction

    task automatic drive_beat(input logic [3:0] st, input logic sg, input logic [9:0] ex, input logic [23:0] mn);
        bus.in_status = st;
        bus.in_sign   = sg;
        bus.in_exp    = ex;
        bus.in_mant   = mn;
        bus.in_valid  = 1'b1;
    endtask

    // Caller sits just after a posedge with in_valid high; returns just after the accepting edge.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          lat, acc, idx, got, seen;
        logic [2:0]  sticky_m;
        logic [31:0] exp_q [$];
        logic [2:0]  expf_q [$];
        bit          done;

        vecs[0]  = '{4'b1001, 1'b1, 10'd0,   24'h000000, 32'h7FC00000, 3'b100};
        vecs[1]  = '{4'b0100, 1'b1, 10'd0,   24'h000000, 32'hFF800000, 3'b000};
        vecs[2]  = '{4'b0000, 1'b0, 10'd127, 24'h800000, 32'h3F800000, 3'b000};
        vecs[3]  = '{4'b0000, 1'b0, 10'd255, 24'h800000, 32'h7F800000, 3'b010};
`ifdef FP_DENORM_OUT_EN
        vecs[4]  = '{4'b0000, 1'b0, 10'h3FD, 24'h800000, 32'h00080000, 3'b000};
        vecs[5]  = '{4'b0000, 1'b0, 10'd0,   24'hC00000, 32'h00600000, 3'b000};
`else
        vecs[4]  = '{4'b0000, 1'b0, 10'h3FD, 24'h800000, 32'h00000000, 3'b001};
        vecs[5]  = '{4'b0000, 1'b0, 10'd0,   24'hC00000, 32'h00000000, 3'b001};
`endif
        vecs[6]  = '{4'b0010, 1'b1, 10'd100, 24'hABCDEF, 32'h80000000, 3'b000};
        vecs[7]  = '{4'b1000, 1'b1, 10'd5,   24'h123456, 32'h7FC00000, 3'b000};
        vecs[8]  = '{4'b1110, 1'b1, 10'd5,   24'h123456, 32'h7FC00000, 3'b000};
        vecs[9]  = '{4'b0110, 1'b0, 10'd5,   24'h123456, 32'h7F800000, 3'b000};
        vecs[10] = '{4'b0000, 1'b1, 10'd254, 24'hFFFFFF, 32'hFF7FFFFF, 3'b000};
        vecs[11] = '{4'b0000, 1'b0, 10'd1,   24'h800001, 32'h00800001, 3'b000};
        vecs[12] = '{4'b0000, 1'b1, 10'd300, 24'h800000, 32'hFF800000, 3'b010};
        vecs[13] = '{4'b0000, 1'b1, 10'h200, 24'hFFFFFF, 32'h80000000, 3'b001};
        vecs[14] = '{4'b0000, 1'b0, 10'd511, 24'h000000, 32'h7F800000, 3'b010};

        bus.in_valid = 1'b0; bus.in_status = '0; bus.in_sign = 1'b0;
        bus.in_exp = '0; bus.in_mant = '0; bus.out_ready = 1'b0; bus.flags_clear = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_flags", bus.out_flags, 0);
        check("rst_sticky", bus.sticky_flags, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_in_ready", bus.in_ready, 1);

        // ---- directed table, one beat at a time ----
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < NVEC; i++) begin
            drive_beat(vecs[i].st, vecs[i].sg, vecs[i].ex, vecs[i].mn);
            wait_accept(ok);
            check("tbl_accept", ok, 1);
            lat = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid) break;
            end
            check("tbl_latency", lat, 2);
            check("tbl_result", bus.out_result, vecs[i].res);
            check("tbl_flags", bus.out_flags, vecs[i].fl);
            $display("vec %0d: result %h flags %b latency %0d", i, bus.out_result, bus.out_flags, lat);
            step();
        end
        @(negedge clk);
        check("tbl_sticky", bus.sticky_flags, 3'b111);

        // ---- lone flags_clear ----
        step();
        bus.flags_clear = 1'b1;
        step();
        bus.flags_clear = 1'b0;
        @(negedge clk);
        check("clear_alone", bus.sticky_flags, 3'b000);

        // ---- backpressure: 3 beats offered, output stalled ----
        step();
        bus.out_ready = 1'b0;
        acc = 0; idx = 0;
        drive_beat(vecs[0].st, vecs[0].sg, vecs[0].ex, vecs[0].mn);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            step();
            if (ok) begin
                acc++;
                idx++;
                drive_beat(vecs[idx].st, vecs[idx].sg, vecs[idx].ex, vecs[idx].mn);
            end
        end
        check("bp_accepted", acc, 2);
        @(negedge clk);
        check("bp_in_ready_low", bus.in_ready, 0);
        for (int c = 0; c < 2; c++) begin
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_result", bus.out_result, vecs[0].res);
            check("bp_hold_flags", bus.out_flags, vecs[0].fl);
            step();
            @(negedge clk);
        end
        step();
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check("bp_result", bus.out_result, vecs[got].res);
                check("bp_flags", bus.out_flags, vecs[got].fl);
                $display("bp out %0d: result %h flags %b", got, bus.out_result, bus.out_flags);
                got++;
            end
            step();
            if (ok) bus.in_valid = 1'b0;
        end
        check("bp_count", got, 3);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
            step();
        end
        check("bp_no_duplicate", seen, 0);

        // ---- flags_clear together with an overflow handshake ----
        bus.flags_clear = 1'b1;
        step();
        bus.flags_clear = 1'b0;
        drive_beat(vecs[0].st, vecs[0].sg, vecs[0].ex, vecs[0].mn);
        wait_accept(ok);
        repeat (4) step();
        @(negedge clk);
        check("pre_clear_sticky", bus.sticky_flags, 3'b100);
        step();
        bus.out_ready = 1'b0;
        drive_beat(vecs[3].st, vecs[3].sg, vecs[3].ex, vecs[3].mn);
        wait_accept(ok);
        check("ovf_accept", ok, 1);
        step();
        @(negedge clk);
        check("ovf_waiting", bus.out_valid, 1);
        step();
        bus.flags_clear = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flags_clear = 1'b0;
        @(negedge clk);
        check("clear_with_handshake", bus.sticky_flags, 3'b010);
        $display("clear+ovf: sticky %b", bus.sticky_flags);

        // ---- reset with two beats in flight ----
        step();
        bus.out_ready = 1'b0;
        drive_beat(vecs[0].st, vecs[0].sg, vecs[0].ex, vecs[0].mn);
        wait_accept(ok);
        drive_beat(vecs[2].st, vecs[2].sg, vecs[2].ex, vecs[2].mn);
        wait_accept(ok);
        check("inflight_accept", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_sticky", bus.sticky_flags, 0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_discarded", seen, 0);
        $display("mid-flight reset: in-flight beats discarded");

        // ---- randomized traffic against the model ----
        step();
        sticky_m = 3'b000;
        done = 1'b0;
        fork
            begin : drv
                logic [3:0]  st;
                logic        sg;
                logic [9:0]  ex;
                logic [23:0] mn;
                logic [31:0] r;
                logic [2:0]  f;
                int          k;
                for (int i = 0; i < NRAND; i++) begin
                    case ($urandom_range(0, 9))
                        0:       st = {3'b100, 1'($urandom_range(0, 1))};
                        1:       st = {2'b01, 2'($urandom_range(0, 3))};
                        2:       st = 4'b0010;
                        default: st = 4'b0000;
                    endcase
                    sg = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0:       ex = 10'(-$urandom_range(0, 40));
                        1:       ex = 10'($urandom_range(250, 300));
                        2:       ex = 10'($urandom_range(1, 254));
                        default: ex = 10'($urandom);
                    endcase
                    mn = 24'($urandom);
                    if ($urandom_range(0, 1) == 0) mn[23] = 1'b1;
                    if ($urandom_range(0, 2) == 0) begin
                        k  = $urandom_range(0, 23);
                        mn = (mn >> k) << k;
                    end
                    model(st, sg, ex, mn, r, f);
                    drive_beat(st, sg, ex, mn);
                    wait_accept(ok);
                    if (!ok) begin
                        check("rand_accept_timeout", 0, 1);
                        break;
                    end
                    exp_q.push_back(r);
                    expf_q.push_back(f);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin : rdy
                while (!done) begin
                    step();
                    bus.out_ready   = ($urandom_range(0, 3) != 0);
                    bus.flags_clear = ($urandom_range(0, 15) == 0);
                end
                bus.flags_clear = 1'b0;
            end
            begin : mon
                int rcv, cyc;
                bit stalled, fire;
                rcv = 0; cyc = 0; stalled = 1'b0;
                while (rcv < NRAND && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    check("rand_sticky", bus.sticky_flags, sticky_m);
                    if (stalled) check("rand_stall_hold", bus.out_valid, 1);
                    fire = bus.out_valid && bus.out_ready;
                    if (bus.out_valid) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_output", 1, 0);
                        end else begin
                            check("rand_result", bus.out_result, exp_q[0]);
                            check("rand_flags", bus.out_flags, expf_q[0]);
                            if (fire) begin
                                $display("rand %0d: result %h flags %b", rcv, bus.out_result, bus.out_flags);
                                sticky_m = bus.flags_clear ? expf_q[0] : (sticky_m | expf_q[0]);
                                void'(exp_q.pop_front());
                                void'(expf_q.pop_front());
                                rcv++;
                            end
                        end
                    end
                    if (!fire && bus.flags_clear) sticky_m = 3'b000;
                    stalled = bus.out_valid && !bus.out_ready;
                end
                check("rand_received", rcv, NRAND);
                done = 1'b1;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_result_composer.md
Name: fp_result_composer

Overview:
- Reverse direction of the operand/operation classifiers: takes an operation status vector plus a raw sign/exponent/mantissa from a datapath and composes the final IEEE-754 result word.
- Specials (NaN, ±inf, ±0), overflow and underflow are encoded here.
- Two-stage valid/ready pipeline between the FP arithmetic core and the writeback stage; keeps sticky exception flags.

Parameters:
- EXP_WIDTH, 8, exponent field width (11 for double).
- MANT_WIDTH, 23, stored mantissa width (52 for double).

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- in_valid  in  1  input beat valid
- in_ready  out  1  composer can accept a beat
- in_status  in  4  {result_is_nan, result_is_clear_inf, result_is_zero, invalid_operation}
- in_sign  in  1  result sign
- in_exp  in  EXP_WIDTH+2  biased exponent, two's complement, may be out of range
- in_mant  in  MANT_WIDTH+1  mantissa with hidden bit at MSB
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  EXP_WIDTH+MANT_WIDTH+1  packed {sign, exp, mant}
- out_flags  out  3  {invalid, overflow, underflow} for this result
- sticky_flags  out  3  OR-accumulation of out_flags over completed output handshakes
- flags_clear  in  1  synchronous clear of sticky_flags

Behaviour:
- Reset: out_valid=0, out_result=0, out_flags=0, sticky_flags=0, all internal valids=0. in_ready=0 while rst is high.
- Reset mid-operation discards in-flight beats. The first cycle after reset has out_valid=0.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - Once out_valid is asserted, out_valid, out_result and out_flags hold stable until out_ready.
  - Each stage loads when it is empty or its downstream accepts.
  - in_ready = !s1_valid || s1_advance, where s1_advance = s2 empty or out_ready.
- Latency and throughput: 2 cycles from input handshake to out_valid with no stall; one result per cycle sustained.
- Stage 1 (classify/select) applies this priority:
  1. result_is_nan: canonical quiet NaN. Sign 0, exp all ones, mant MSB 1, rest 0. invalid flag = in_status[0].
  2. result_is_clear_inf: ±inf from in_sign, mant 0.
  3. result_is_zero: ±0 from in_sign.
  4. Otherwise normal path:
     - in_exp >= 2^EXP_WIDTH−1: ±inf, overflow=1.
     - in_exp <= 0: underflow handling (see Optional Feature).
     - else: exp = in_exp[EXP_WIDTH-1:0], mant = in_mant[MANT_WIDTH-1:0]. Hidden bit dropped, no rounding.
- Stage 2: registers the packed word and flags.
- Sticky update: sticky_flags |= out_flags on each output handshake. If flags_clear and a handshake occur in the same cycle, sticky = out_flags of that beat (new flags win).

Optional Feature:
- Macro: FP_DENORM_OUT_EN
- Defined:
  - For 1−MANT_WIDTH <= in_exp <= 0: output is a denormal, exp=0, mant = (in_mant >> (1−in_exp))[MANT_WIDTH-1:0], truncated.
  - underflow=1 only if shifted-out bits are non-zero or the result mant is 0.
  - in_exp < 1−MANT_WIDTH: signed zero, underflow=1.
  - Barrel shift lives in stage 1.
- Undefined: any in_exp <= 0 flushes to signed zero with underflow=1; no shifter is synthesized.

Decomposition:
- Package fp_pkg:
  - width localparams derived from IS_DOUBLE;
  - status bit indices (STAT_NAN=3, STAT_INF=2, STAT_ZERO=1, STAT_INVALID=0);
  - flag indices (FLG_INVALID=2, FLG_OVF=1, FLG_UNF=0);
  - canonical qNaN / inf constant functions.
- Sub-module fp_pipe_stage: parameterised-width valid/ready register slice, instantiated for stage 1 and stage 2.

Test Plan:
- NaN path: in_status=4'b1001, sign=1 → after 2 cycles out_result=32'h7FC00000, out_flags=3'b100.
- Infinity path: in_status=4'b0100, sign=1 → 32'hFF800000, flags 3'b000.
- Normal path: in_status=0, sign=0, in_exp=127, in_mant=24'h800000 → 32'h3F800000, flags 0.
- Overflow/underflow:
  - in_exp=255 → 32'h7F800000, flags 3'b010.
  - in_exp=−3, macro undefined → 32'h00000000, flags 3'b001.
  - Macro defined, in_exp=0, in_mant=24'hC00000 → 32'h00600000, flags 0.
- Backpressure: hold out_ready=0 for 5 cycles while offering 3 beats → exactly 2 accepted, then in_ready=0. After release, 3 results appear in order with no loss or duplication, and the output stays stable while stalled.
- Flags and reset:
  - flags_clear in the same cycle as an overflow handshake → sticky_flags=3'b010.
  - rst asserted with 2 beats in flight → out_valid=0 next cycle, sticky_flags=0.
